// File: rtl/univ_shift_reg.sv
// Universal N-bit register: parallel load/hold, logical/arithmetic/rotate shifts,
// serial in/out at both ends, and a saturating shift counter with a drained flag.
module univ_shift_reg #(
    parameter int             N         = 4,
    parameter logic [N-1:0]   RESET_VAL = '0,
    parameter int             CW        = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic [N-1:0]  I,
    input  logic          sin_l,
    input  logic          sin_r,
    output logic [N-1:0]  Q,
    output logic          sout_r,
    output logic          sout_l,
    output logic [CW-1:0] shift_cnt,
    output logic          drained
);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_LOAD  = 3'b001,
        M_SHR   = 3'b010,
        M_SHL   = 3'b011,
        M_ROR   = 3'b100,
        M_ROL   = 3'b101,
        M_ASR   = 3'b110,
        M_CLEAR = 3'b111
    } mode_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(N);

    mode_t               mode_sel;
    logic signed [N-1:0] q_signed;
    logic [N-1:0]        q_nxt;
    logic [CW-1:0]       cnt_nxt;
    logic                drn_nxt;
    logic                is_shift;

    assign mode_sel = mode_t'(mode);
    assign q_signed = Q;
    assign sout_r   = Q[0];
    assign sout_l   = Q[N-1];

    always_comb begin
        q_nxt    = Q;
        cnt_nxt  = shift_cnt;
        drn_nxt  = drained;
        is_shift = 1'b0;
        if (en) begin
            case (mode_sel)
                M_HOLD:  q_nxt = Q;
                M_LOAD: begin
                    q_nxt   = I;
                    cnt_nxt = '0;
                    drn_nxt = 1'b0;
                end
                M_SHR: begin
                    q_nxt    = {sin_l, Q[N-1:1]};
                    is_shift = 1'b1;
                end
                M_SHL: begin
                    q_nxt    = {Q[N-2:0], sin_r};
                    is_shift = 1'b1;
                end
                M_ROR:   q_nxt = {Q[0], Q[N-1:1]};
                M_ROL:   q_nxt = {Q[N-2:0], Q[N-1]};
                M_ASR: begin
                    q_nxt    = q_signed >>> 1;
                    is_shift = 1'b1;
                end
                M_CLEAR: begin
                    q_nxt   = RESET_VAL;
                    cnt_nxt = '0;
                    drn_nxt = 1'b1;
                end
                default: q_nxt = Q;
            endcase
        end
        // Lossy shifts count up to N and stop; drained latches once the last loaded bit leaves.
        if (is_shift && (shift_cnt != CNT_MAX)) begin
            cnt_nxt = shift_cnt + 1'b1;
            if (cnt_nxt == CNT_MAX)
                drn_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q         <= RESET_VAL;
            shift_cnt <= '0;
            drained   <= 1'b1;
        end else begin
            Q         <= q_nxt;
            shift_cnt <= cnt_nxt;
            drained   <= drn_nxt;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed and random checks of univ_shift_reg at N=4 and N=8 against an arithmetic reference model.
module tb_univ_shift_reg;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] I8;
    logic       sin_l;
    logic       sin_r;

    logic [3:0] Q4;
    logic       sout_r4, sout_l4, drn4;
    logic [2:0] cnt4;
    logic [7:0] Q8;
    logic       sout_r8, sout_l8, drn8;
    logic [3:0] cnt8;

    int mq4, mc4, md4;
    int mq8, mc8, md8;
    int errors = 0;
    int checks = 0;

    univ_shift_reg #(.N(4), .RESET_VAL(4'h0)) u4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .I(I8[3:0]),
        .sin_l(sin_l), .sin_r(sin_r), .Q(Q4), .sout_r(sout_r4), .sout_l(sout_l4),
        .shift_cnt(cnt4), .drained(drn4)
    );

    univ_shift_reg #(.N(8), .RESET_VAL(8'hA5)) u8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .I(I8),
        .sin_l(sin_l), .sin_r(sin_r), .Q(Q8), .sout_r(sout_r8), .sout_l(sout_l8),
        .shift_cnt(cnt8), .drained(drn8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: registers as integers, operations as plain shift/or/mask arithmetic.
    task automatic model_step(input int n, input int rv, input int m, input int i,
                              input int sl, input int sr,
                              inout int q, inout int c, inout int d);
        int full, msb, lsb;
        bit lossy;
        full  = (1 << n) - 1;
        msb   = (q >> (n - 1)) & 1;
        lsb   = q & 1;
        lossy = 1'b0;
        case (m)
            1: begin q = i & full; c = 0; d = 0; end
            2: begin q = (q >> 1) | (sl << (n - 1)); lossy = 1'b1; end
            3: begin q = ((q << 1) | sr) & full; lossy = 1'b1; end
            4: q = (q >> 1) | (lsb << (n - 1));
            5: q = ((q << 1) | msb) & full;
            6: begin q = (q >> 1) | (msb << (n - 1)); lossy = 1'b1; end
            7: begin q = rv; c = 0; d = 1; end
            default: ;
        endcase
        if (lossy) begin
            if (c < n) c++;
            if (c == n) d = 1;
        end
    endtask

    task automatic model_reset();
        mq4 = 0;    mc4 = 0; md4 = 1;
        mq8 = 'hA5; mc8 = 0; md8 = 1;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".q4"},    32'(Q4),      mq4);
        chk({tag, ".sr4"},   32'(sout_r4), mq4 & 1);
        chk({tag, ".sl4"},   32'(sout_l4), (mq4 >> 3) & 1);
        chk({tag, ".cnt4"},  32'(cnt4),    mc4);
        chk({tag, ".drn4"},  32'(drn4),    md4);
        chk({tag, ".q8"},    32'(Q8),      mq8);
        chk({tag, ".sr8"},   32'(sout_r8), mq8 & 1);
        chk({tag, ".sl8"},   32'(sout_l8), (mq8 >> 7) & 1);
        chk({tag, ".cnt8"},  32'(cnt8),    mc8);
        chk({tag, ".drn8"},  32'(drn8),    md8);
    endtask

    task automatic step(input string tag, input logic e, input logic [2:0] m,
                        input logic [7:0] i, input logic sl, input logic sr);
        en = e; mode = m; I8 = i; sin_l = sl; sin_r = sr;
        @(posedge clk);
        if (e) begin
            model_step(4, 0,     int'(m), int'(i), int'(sl), int'(sr), mq4, mc4, md4);
            model_step(8, 'hA5,  int'(m), int'(i), int'(sl), int'(sr), mq8, mc8, md8);
        end
        #1;
        compare_all(tag);
    endtask

    // Assert reset between edges, check it took effect without a clock, release after the next edge.
    task automatic reset_pulse(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [3:0] seq;
        logic [3:0] pat;

        reset = 1'b1; en = 1'b0; mode = 3'd0; I8 = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all("por");
        reset = 1'b0;

        // Reset mid-operation
        step("pre_load", 1'b1, 3'd1, 8'h0B, 1'b0, 1'b0);
        en = 1'b1; mode = 3'd2;
        reset_pulse("mid_rst");
        chk("t1_rst_q4", 32'(Q4), 32'h0);
        chk("t1_rst_drn4", 32'(drn4), 32'h1);
        chk("t1_rst_q8", 32'(Q8), 32'hA5);

        step("t1_load", 1'b1, 3'd1, 8'h0B, 1'b0, 1'b0);
        chk("t1_load_q4", 32'(Q4), 32'hB);
        chk("t1_load_drn4", 32'(drn4), 32'h0);

        // Parallel-in, serial-out drain
        seq = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            chk("t2_sout_r", 32'(sout_r4), 32'(seq[k]));
            step("t2_shr", 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
            chk("t2_cnt4", 32'(cnt4), 32'(k + 1));
            chk("t2_drn4", 32'(drn4), (k == 3) ? 32'h1 : 32'h0);
        end
        chk("t2_q4_empty", 32'(Q4), 32'h0);
        step("t2_shr5", 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
        chk("t2_cnt4_sat", 32'(cnt4), 32'h4);

        // Serial-in, parallel-out fill
        step("t3_clear", 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        pat = 4'b1001;
        for (int k = 0; k < 4; k++)
            step("t3_shl", 1'b1, 3'd3, 8'h00, 1'b0, pat[3 - k]);
        chk("t3_q4", 32'(Q4), 32'h9);
        chk("t3_cnt4", 32'(cnt4), 32'h4);
        chk("t3_drn4", 32'(drn4), 32'h1);

        // Rotates then arithmetic shifts
        step("t4_load", 1'b1, 3'd1, 8'h09, 1'b0, 1'b0);
        step("t4_rol", 1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
        chk("t4_rol_q4", 32'(Q4), 32'h3);
        step("t4_ror", 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        chk("t4_ror_q4", 32'(Q4), 32'h9);
        chk("t4_rot_cnt4", 32'(cnt4), 32'h0);
        step("t4_asr1", 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        chk("t4_asr1_q4", 32'(Q4), 32'hC);
        step("t4_asr2", 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        chk("t4_asr2_q4", 32'(Q4), 32'hE);
        chk("t4_asr_cnt4", 32'(cnt4), 32'h2);

        // Enable gating and hold
        step("t5_load", 1'b1, 3'd1, 8'h06, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            step("t5_en0", 1'b0, 3'd3, 8'hFF, 1'b1, 1'b1);
        chk("t5_q4", 32'(Q4), 32'h6);
        chk("t5_cnt4", 32'(cnt4), 32'h0);
        step("t5_hold", 1'b1, 3'd0, 8'hFF, 1'b1, 1'b1);
        chk("t5_hold_q4", 32'(Q4), 32'h6);

        // Eight-bit instance: reset value, clear, drain timing
        reset_pulse("t6_rst");
        chk("t6_rst_q8", 32'(Q8), 32'hA5);
        step("t6_load", 1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
        chk("t6_load_q8", 32'(Q8), 32'h3C);
        step("t6_clear", 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        chk("t6_clr_q8", 32'(Q8), 32'hA5);
        chk("t6_clr_drn8", 32'(drn8), 32'h1);
        step("t6_load2", 1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step("t6_shr", 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
            chk("t6_drn8", 32'(drn8), (k == 7) ? 32'h1 : 32'h0);
        end
        chk("t6_cnt8", 32'(cnt8), 32'h8);

        // Random operation mix with occasional asynchronous resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0)
                reset_pulse("rnd_rst");
            else
                step("rnd", $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
                     8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register and the next generation of the 4-bit PIPO load register. It keeps the parallel load/hold behaviour and adds the following:
- logical, arithmetic and rotate shifts in both directions
- serial in/out at both ends
- a synchronous clear
- a global enable
- a shift counter with a "drained" flag, so a parallel-loaded word can be streamed out serially

It sits between parallel datapaths and serial links (PISO/SIPO/PIPO use from one block).

Parameters:
N, 4, register width in bits; legal range N >= 2.
RESET_VAL, 0, value loaded into Q on reset and by the CLEAR mode; N bits wide.
CW, $clog2(N+1), shift counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
en  input  1  global enable; 0 forces HOLD regardless of mode.
mode  input  3  operation select (encoding in Behaviour).
I  input  N  parallel data in.
sin_l  input  1  serial in entering at MSB on logical shift right.
sin_r  input  1  serial in entering at LSB on shift left.
Q  output  N  register contents (registered).
sout_r  output  1  Q[0], combinational from register.
sout_l  output  1  Q[N-1], combinational from register.
shift_cnt  output  CW  count of non-rotate shifts since last LOAD/CLEAR/reset, saturating at N.
drained  output  1  1 when shift_cnt == N or after reset/CLEAR (no unshifted loaded data remains).

Behaviour:
Reset:
- reset=1 asynchronously sets Q=RESET_VAL, shift_cnt=0, drained=1.
- Reset dominates all other inputs, including mid-shift.

Update rule:
- All state updates occur on the rising edge of clk.
- en=0 means HOLD: no state changes.

Mode encoding (applies when en=1):
- 000 HOLD: Q, shift_cnt and drained unchanged.
- 001 LOAD: Q<=I, shift_cnt<=0, drained<=0.
- 010 SHR: Q<={sin_l, Q[N-1:1]}.
- 011 SHL: Q<={Q[N-2:0], sin_r}.
- 100 ROR: Q<={Q[0], Q[N-1:1]}.
- 101 ROL: Q<={Q[N-2:0], Q[N-1]}.
- 110 ASR: Q<={Q[N-1], Q[N-1:1]} (MSB replicated).
- 111 CLEAR: Q<=RESET_VAL, shift_cnt<=0, drained<=1.

Counter:
- SHR, SHL and ASR increment shift_cnt, saturating at N.
- drained<=1 on the edge where shift_cnt goes N-1 -> N. drained stays 1 until the next LOAD.
- Shifts continue to operate on Q after drained=1; the count holds at N.
- ROR and ROL leave shift_cnt and drained unchanged, since no data is lost.

Latency and serial outputs:
- Latency is one cycle: Q reflects the operation on the edge after mode is presented.
- sout_l and sout_r present the bit that the next SHL or SHR respectively will discard.

Boundary cases:
- Simultaneous events: mode is a single select, so only one operation per cycle. en=0 has priority over mode.
- Reset deasserting mid-stream leaves the block at RESET_VAL with drained=1. A new LOAD is required before a fresh shift count starts.
- No X propagation: all 8 mode codes are defined.
- Counter width: the saturating counter never wraps.

Test Plan:
1. Reset and load, N=4: assert reset mid-operation -> Q=0000, shift_cnt=0, drained=1 immediately (before next edge). Then LOAD I=1011 -> Q=1011, shift_cnt=0, drained=0.
2. PISO drain: after LOAD 1011, 4 x SHR with sin_l=0 -> sout_r sequence 1,1,0,1 and Q ends 0000. shift_cnt=1,2,3,4; drained rises on the 4th edge. A 5th SHR keeps shift_cnt=4.
3. SIPO fill: CLEAR, then 4 x SHL with sin_r=1,0,0,1 -> Q=1001. shift_cnt=4 and drained=1 on the 4th edge.
4. Rotate and arithmetic shift: LOAD 1001, ROL -> 0011, ROR -> 1001, shift_cnt stays 0. Then ASR -> 1100, ASR -> 1110, shift_cnt=2.
5. Enable and hold: LOAD 0110, then en=0 with mode=SHL for 3 cycles -> Q=0110, shift_cnt=0. Then mode=HOLD with en=1 -> Q unchanged.
6. Parametrisation: N=8, RESET_VAL=8'hA5. Reset -> Q=A5. LOAD 8'h3C, then CLEAR -> Q=A5, drained=1. 8 x SHR -> drained asserts on the 8th edge only.
